// File: rtl/smvm_result_collector.sv
`default_nettype none
// ============================================================================
// smvm_result_collector : buffers SMVM row results in a FIFO tagged by row.
// Revision 1.0
// ============================================================================
module smvm_result_collector #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [7:0]             rows_in_i,
    input  logic                   clear_i,
    input  logic                   in_valid_i,
    input  logic [13:0]            data_in_i,
    input  logic                   out_ready_i,
    output logic                   out_valid_o,
    output logic [13:0]            data_out_o,
    output logic [6:0]             row_idx_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overflow_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    rows_q, rows_d;
    logic [7:0]    rcvd_q, rcvd_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic [20:0]   mem_q [DEPTH];
    logic [20:0]   head;
    logic          full, push, pop, drop;

    assign full = (count_q == (AW+1)'(DEPTH));
    assign pop  = (count_q != '0) && out_ready_i && !clear_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = (state_q == S_COLLECT) && in_valid_i && !clear_i && (!full || pop);
    assign drop = (state_q == S_COLLECT) && in_valid_i && full && !pop;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        rcvd_d     = rcvd_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            state_d    = S_IDLE;
            rcvd_d     = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (rows_in_i != 8'd0) begin
                            rows_d     = rows_in_i;
                            rcvd_d     = '0;
                            overflow_d = 1'b0;
                            state_d    = S_COLLECT;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_COLLECT: begin
                    if (in_valid_i) begin
                        rcvd_d = rcvd_q + 8'd1;
                        if (drop) overflow_d = 1'b1;
                        if (rcvd_q + 8'd1 == rows_q) state_d = S_DRAIN;
                    end
                end
                S_DRAIN: if (count_q == '0) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            rcvd_q     <= '0;
            overflow_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            rcvd_q     <= rcvd_d;
            overflow_q <= overflow_d;
            if (clear_i) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {rcvd_q[6:0], data_in_i};
    end

    assign head        = mem_q[rptr_q];
    assign out_valid_o = (count_q != '0);
    assign data_out_o  = out_valid_o ? head[13:0]  : '0;
    assign row_idx_o   = out_valid_o ? head[20:14] : '0;
    assign count_o     = count_q;
    assign busy_o      = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    assign done_o      = (state_q == S_DONE);
    assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_smvm_result_collector.sv
`default_nettype none
// ============================================================================
// tb_smvm_result_collector : directed self-checking bench for the collector.
// Revision 1.0
// ============================================================================
module tb_smvm_result_collector;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  rows_in_i = '0;
    logic        clear_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [13:0] data_in_i = '0;
    logic        out_ready_i = 1'b0;
    logic        out_valid_o;
    logic [13:0] data_out_o;
    logic [6:0]  row_idx_o;
    logic [4:0]  count_o;
    logic        busy_o, done_o, overflow_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [20:0] got_q[$];
    logic [20:0] exp_q[$];

    smvm_result_collector #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .rows_in_i  (rows_in_i),
        .clear_i    (clear_i),
        .in_valid_i (in_valid_i),
        .data_in_i  (data_in_i),
        .out_ready_i(out_ready_i),
        .out_valid_o(out_valid_o),
        .data_out_o (data_out_o),
        .row_idx_o  (row_idx_o),
        .count_o    (count_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so mid-cycle sampling sees every pop once.
    always @(negedge clk) begin
        if (out_valid_o && out_ready_i) got_q.push_back({row_idx_o, data_out_o});
        if (done_o) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [13:0] d);
        in_valid_i = 1'b1;
        data_in_i  = d;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic begin_run(input logic [7:0] rows);
        start_i   = 1'b1;
        rows_in_i = rows;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int k = 0; k < lim && !done_o; k++) tick();
        check("done_seen", 32'(done_o), 32'd1);
        tick();
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_data"},  32'(data_out_o),  32'd0);
        check({tag, "_row"},   32'(row_idx_o),   32'd0);
        check({tag, "_count"}, 32'(count_o),     32'd0);
        check({tag, "_busy"},  32'(busy_o),      32'd0);
        check({tag, "_done"},  32'(done_o),      32'd0);
        check({tag, "_ovf"},   32'(overflow_o),  32'd0);
    endtask

    initial begin
        int d0;
        #1;
        check_all_zero("reset");
        #10 rst_n = 1'b1;
        tick();

        // Basic pass-through, including one-cycle write-to-head latency
        out_ready_i = 1'b1;
        got_q.delete(); exp_q.delete(); d0 = done_cnt;
        begin_run(8'd3);
        check("basic_busy", 32'(busy_o), 32'd1);
        push(14'd5);
        check("basic_lat_valid", 32'(out_valid_o), 32'd1);
        check("basic_lat_data", 32'(data_out_o), 32'd5);
        push(14'h3FFE);
        push(14'h1FFF);
        wait_done(10);
        exp_q = '{{7'd0, 14'd5}, {7'd1, 14'h3FFE}, {7'd2, 14'h1FFF}};
        compare_words("basic");
        check("basic_ndone", 32'(done_cnt - d0), 32'd1);
        check("basic_ovf", 32'(overflow_o), 32'd0);

        // Backpressure and overflow: rows 16..19 dropped
        out_ready_i = 1'b0;
        got_q.delete(); exp_q.delete(); d0 = done_cnt;
        begin_run(8'd20);
        for (int i = 0; i < 20; i++) push(14'(i * 5 - 40));
        check("ovf_count", 32'(count_o), 32'd16);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_busy", 32'(busy_o), 32'd1);
        check("ovf_nodone", 32'(done_cnt - d0), 32'd0);
        out_ready_i = 1'b1;
        wait_done(40);
        for (int i = 0; i < 16; i++) exp_q.push_back({7'(i), 14'(i * 5 - 40)});
        compare_words("ovf");
        check("ovf_sticky", 32'(overflow_o), 32'd1);

        // Full FIFO with simultaneous push and pop
        out_ready_i = 1'b0;
        got_q.delete(); exp_q.delete();
        begin_run(8'd17);
        for (int i = 0; i < 16; i++) push(14'(200 + i));
        check("full_count", 32'(count_o), 32'd16);
        out_ready_i = 1'b1;
        push(14'd999);
        check("pp_count", 32'(count_o), 32'd16);
        check("pp_ovf", 32'(overflow_o), 32'd0);
        wait_done(40);
        for (int i = 0; i < 16; i++) exp_q.push_back({7'(i), 14'(200 + i)});
        exp_q.push_back({7'd16, 14'd999});
        compare_words("pp");

        // Zero rows: done in the cycle after the start edge, then gone
        d0 = done_cnt;
        begin_run(8'd0);
        check("zero_done", 32'(done_o), 32'd1);
        check("zero_valid", 32'(out_valid_o), 32'd0);
        tick();
        check("zero_done_off", 32'(done_o), 32'd0);
        check("zero_ndone", 32'(done_cnt - d0), 32'd1);

        // Clear mid-COLLECT, then a fresh 2-row run
        out_ready_i = 1'b0;
        d0 = done_cnt;
        begin_run(8'd10);
        for (int i = 0; i < 4; i++) push(14'(i + 1));
        check("clr_pre_count", 32'(count_o), 32'd4);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_count", 32'(count_o), 32'd0);
        check("clr_busy", 32'(busy_o), 32'd0);
        check("clr_valid", 32'(out_valid_o), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("clr_nodone", 32'(done_cnt - d0), 32'd0);
        out_ready_i = 1'b1;
        got_q.delete(); exp_q.delete();
        begin_run(8'd2);
        push(14'd7);
        push(14'h3F9C);
        wait_done(10);
        exp_q = '{{7'd0, 14'd7}, {7'd1, 14'h3F9C}};
        compare_words("rerun");

        // Asynchronous reset between edges during DRAIN
        out_ready_i = 1'b0;
        begin_run(8'd3);
        push(14'd11); push(14'd12); push(14'd13);
        check("arst_pre_count", 32'(count_o), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        #2 rst_n = 1'b1;
        tick();
        check("arst_post_count", 32'(count_o), 32'd0);
        check("arst_post_busy", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
